// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and constants for the load/store unit
//
// Purpose: access-size and FSM-state encodings, data-memory geometry, and the
// access-legality check used by the LSU.
// Ports: none (package).
package lsu_pkg;

  localparam int DM_WORDS = 64;
  localparam int DM_ABITS = 6;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  // lo = addr[1:0], hi_nz = any of addr[31:8] set (outside the 256-byte window)
  function automatic logic access_err(logic [1:0] sz, logic [1:0] lo, logic hi_nz);
    return (sz == SZ_ILL) ||
           ((sz == SZ_HALF) && lo[0]) ||
           ((sz == SZ_WORD) && (lo != 2'b00)) ||
           hi_nz;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte/half lane extract-extend for loads and lane merge for stores
//
// Purpose: purely combinational lane logic shared by the load path and the
// read-modify-write merge path.
// Ports:
//   size  - access size (byte/half/word)
//   lane  - addr[1:0]; half accesses use lane[1] only
//   sext  - sign-extend sub-word load results
//   rword - word read from memory
//   wdata - right-aligned store data
//   ldata - extracted, extended load result
//   mword - rword with the target lane(s) replaced by wdata
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sext,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mword
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b     = rword[{lane, 3'b000} +: 8];
    h     = lane[1] ? rword[31:16] : rword[15:0];
    ldata = rword;
    mword = wdata;
    case (size)
      SZ_BYTE: begin
        ldata = {{24{sext & b[7]}}, b};
        mword = rword;
        mword[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ldata = {{16{sext & h[15]}}, h};
        mword = rword;
        if (lane[1]) mword[31:16] = wdata[15:0];
        else         mword[15:0]  = wdata[15:0];
      end
      default: begin
        ldata = rword;
        mword = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit with read-modify-write for sub-word stores
//
// Purpose: accepts one access per cycle in IDLE; loads and word stores finish
// in one cycle, byte/half stores read the word, then write the merged word in
// MERGE. Illegal accesses touch no memory and return resp_err.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   req, we, size, sext, addr, wdata - access request (sampled while ready=1)
//   ready                         - high in IDLE
//   resp_valid, resp_err, resp_data - one-cycle completion response
//   dm_addr, dm_rd, dm_wr, dm_wdata, dm_rdata - word-wide data-memory port
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_data,
  output logic [31:0] dm_addr,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  state_e                state, state_nx;
  logic [DM_ABITS-1:0]   lat_idx;
  logic [1:0]            lat_lane;
  logic [1:0]            lat_size;
  logic [31:0]           lat_wdata;
  logic [31:0]           lat_rdata;

  logic                  acc, bad;
  logic [1:0]            ln_size, ln_lane;
  logic [31:0]           ln_word, ln_wdata, ln_ldata, ln_mword;

  assign ready = (state == ST_IDLE);
  assign acc   = req && ready;
  assign bad   = access_err(size, addr[1:0], |addr[31:8]);

  lsu_lane u_lane (
    .size  (ln_size),
    .lane  (ln_lane),
    .sext  (sext),
    .rword (ln_word),
    .wdata (ln_wdata),
    .ldata (ln_ldata),
    .mword (ln_mword)
  );

  always_comb begin
    state_nx = state;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    // lane logic sees the live request in IDLE and the latched store in MERGE
    ln_size  = size;
    ln_lane  = addr[1:0];
    ln_word  = dm_rdata;
    ln_wdata = wdata;
    case (state)
      ST_IDLE: begin
        if (acc && !bad) begin
          dm_addr = {{(32-DM_ABITS){1'b0}}, addr[DM_ABITS+1:2]};
          if (!we) begin
            dm_rd = 1'b1;
          end else if (size == SZ_WORD) begin
            dm_wr    = 1'b1;
            dm_wdata = wdata;
          end else begin
            dm_rd    = 1'b1;
            state_nx = ST_MERGE;
          end
        end
      end
      ST_MERGE: begin
        ln_size  = lat_size;
        ln_lane  = lat_lane;
        ln_word  = lat_rdata;
        ln_wdata = lat_wdata;
        dm_rd    = 1'b1;
        dm_wr    = 1'b1;
        dm_addr  = {{(32-DM_ABITS){1'b0}}, lat_idx};
        dm_wdata = ln_mword;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      lat_idx    <= '0;
      lat_lane   <= '0;
      lat_size   <= '0;
      lat_wdata  <= '0;
      lat_rdata  <= '0;
    end else begin
      state      <= state_nx;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      if (state == ST_MERGE) begin
        resp_valid <= 1'b1;
      end else if (acc) begin
        if (bad) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end else if (!we) begin
          resp_valid <= 1'b1;
          resp_data  <= ln_ldata;
        end else if (size == SZ_WORD) begin
          resp_valid <= 1'b1;
        end else begin
          lat_idx   <= addr[DM_ABITS+1:2];
          lat_lane  <= addr[1:0];
          lat_size  <= size;
          lat_wdata <= wdata;
          lat_rdata <= dm_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for the load/store unit
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        sext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, resp_valid, resp_err, dm_rd, dm_wr;
  logic [31:0] resp_data, dm_addr, dm_wdata, dm_rdata;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  int vectors = 0;
  int miscompares = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .size       (size),
    .sext       (sext),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_data  (resp_data),
    .dm_addr    (dm_addr),
    .dm_rd      (dm_rd),
    .dm_wr      (dm_wr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata)
  );

  assign dm_rdata = mem[dm_addr[5:0]];

  always @(posedge clk) begin
    if (dm_rd) rd_cnt <= rd_cnt + 1;
    if (dm_wr) wr_cnt <= wr_cnt + 1;
    if (dm_wr)      mem[dm_addr[5:0]] <= dm_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  // Reference: byte-addressed view of the 256-byte window, updated in program order.
  function automatic void model(input logic w, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] d);
    longint unsigned m;
    logic [31:0] m32, word, v;
    int sh;
    e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 256);
    d = '0;
    if (!e) begin
      m   = (64'd1 << (8 * (1 << sz))) - 1;
      m32 = m[31:0];
      sh  = int'(a % 4) * 8;
      word = ref_mem[a / 4];
      if (!w) begin
        v = (word >> sh) & m32;
        if (sx && sz != 2'd2 && v >= (m32 >> 1) + 1) v = v | ~m32;
        d = v;
      end else begin
        ref_mem[a / 4] = (word & ~(m32 << sh)) | ((wd & m32) << sh);
      end
    end
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[5:0]; pl_data = d;
    ref_mem[idx] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic e, sub;
    logic [31:0] d;
    int r0, w0, cyc, xr, xw, nd;
    model(w, sz, sx, a, wd, e, d);
    sub = !e && w && sz != 2'd2;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    r0 = rd_cnt; w0 = wr_cnt;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++; $display("FAIL %s ready_before: got %b want 1", tag, ready);
    end
    @(posedge clk); #1;
    req = 1'b0;
    if (sub) begin
      vectors++;
      if (ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'd0) begin
        miscompares++;
        $display("FAIL %s merge_phase: ready=%b valid=%b data=%h want 0/0/0", tag, ready, resp_valid, resp_data);
      end
    end
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 4) begin
      @(posedge clk); #1; cyc++;
    end
    vectors++;
    if (resp_valid !== 1'b1 || cyc != (sub ? 1 : 0) || resp_err !== e || resp_data !== d) begin
      miscompares++;
      $display("FAIL %s resp: valid=%b lat=%0d err=%b data=%h want valid=1 lat=%0d err=%b data=%h",
               tag, resp_valid, cyc, resp_err, resp_data, sub ? 1 : 0, e, d);
    end
    xr = e ? 0 : (!w ? 1 : (sub ? 2 : 0));
    xw = (!e && w) ? 1 : 0;
    vectors++;
    if (rd_cnt - r0 != xr || wr_cnt - w0 != xw) begin
      miscompares++;
      $display("FAIL %s dm_enables: rd=%0d wr=%0d want rd=%0d wr=%0d", tag, rd_cnt - r0, wr_cnt - w0, xr, xw);
    end
    @(posedge clk); #1;
    vectors++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_data !== 32'd0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s single_pulse: valid=%b err=%b data=%h ready=%b want 0/0/0/1", tag, resp_valid, resp_err, resp_data, ready);
    end
    nd = mem_diffs();
    vectors++;
    if (nd != 0) begin
      miscompares++; $display("FAIL %s memory: %0d words differ want 0", tag, nd);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_data !== 32'd0 ||
        dm_rd !== 1'b0 || dm_wr !== 1'b0 || dm_addr !== 32'd0 || dm_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid=%b err=%b data=%h rd=%b wr=%b addr=%h wd=%h",
               ready, resp_valid, resp_err, resp_data, dm_rd, dm_wr, dm_addr, dm_wdata);
    end
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(1, 32'h8899AABB);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (dm_addr !== 32'd0 || dm_wdata !== 32'd0 || dm_rd !== 1'b0 || dm_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_outputs: addr=%h wd=%h rd=%b wr=%b want all 0", dm_addr, dm_wdata, dm_rd, dm_wr);
    end
  endtask

  task automatic test_directed();
    access(1'b0, 2'd0, 1'b1, 32'd5, 32'd0, "load_byte_sext");
    vectors++;
    if (ref_mem[1] !== 32'h8899AABB) begin
      miscompares++; $display("FAIL preload_check: got %h want 8899aabb", ref_mem[1]);
    end
    access(1'b1, 2'd1, 1'b0, 32'd6, 32'h1234, "store_half_rmw");
    vectors++;
    if (mem[1] !== 32'h1234AABB) begin
      miscompares++; $display("FAIL half_merge_word: got %h want 1234aabb", mem[1]);
    end
    access(1'b1, 2'd2, 1'b0, 32'd2, 32'hDEADBEEF, "word_store_misaligned");
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, "load_out_of_range");
    access(1'b0, 2'd3, 1'b0, 32'd8, 32'd0, "illegal_size");
    access(1'b0, 2'd1, 1'b0, 32'd7, 32'd0, "half_odd");
    access(1'b0, 2'd1, 1'b0, 32'd6, 32'd0, "load_half_zext");
  endtask

  task automatic test_merge_hold();
    logic e1, e2;
    logic [31:0] d1, exp_load;
    model(1'b1, 2'd0, 1'b0, 32'd12, 32'hA5A5A55A, e1, d1);
    model(1'b0, 2'd2, 1'b0, 32'd12, 32'd0, e2, exp_load);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'd12; wdata = 32'hA5A5A55A;
    @(posedge clk); #1;
    we = 1'b0; size = 2'd2; addr = 32'd12; wdata = 32'd0;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL hold_ready_low: got %b want 0", ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 32'd0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_store_resp: valid=%b err=%b data=%h ready=%b want 1/0/0/1", resp_valid, resp_err, resp_data, ready);
    end
    @(posedge clk); #1;
    req = 1'b0;
    vectors++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== exp_load) begin
      miscompares++;
      $display("FAIL hold_load_resp: valid=%b err=%b data=%h want 1/0/%h", resp_valid, resp_err, resp_data, exp_load);
    end
    @(posedge clk); #1;
    vectors++;
    if (mem_diffs() != 0 || resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL hold_memory: %0d words differ valid=%b want 0/0", mem_diffs(), resp_valid);
    end
  endtask

  task automatic test_reset_in_merge();
    logic [31:0] old;
    int w0;
    old = ref_mem[0];
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'd0; wdata = 32'h000000C3;
    @(posedge clk); #1;
    req = 1'b0;
    vectors++;
    if (ready !== 1'b0 || dm_wr !== 1'b1) begin
      miscompares++; $display("FAIL rst_merge_entry: ready=%b wr=%b want 0/1", ready, dm_wr);
    end
    #1 rst = 1'b1;
    #1;
    w0 = wr_cnt;
    vectors++;
    if (ready !== 1'b1 || dm_wr !== 1'b0 || dm_rd !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_merge_abort: ready=%b wr=%b rd=%b valid=%b want 1/0/0/0", ready, dm_wr, dm_rd, resp_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (resp_valid !== 1'b0 || wr_cnt != w0 || mem[0] !== old) begin
      miscompares++;
      $display("FAIL rst_merge_mem: valid=%b writes=%0d mem0=%h want 0/0/%h", resp_valid, wr_cnt - w0, mem[0], old);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = $urandom_range(0, 255);
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic w, e, sx;
    logic [1:0] sz;
    logic [31:0] a, wd, d;
    int w0, stores;
    w0 = wr_cnt;
    stores = 0;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i < 12) begin
        w  = 1'($urandom_range(0, 1));
        sz = w ? 2'd2 : 2'($urandom_range(0, 2));
        a  = $urandom_range(0, 7) * 4;
        if (sz == 2'd0) a = a + $urandom_range(0, 3);
        if (sz == 2'd1) a = a + $urandom_range(0, 1) * 2;
        sx = 1'($urandom_range(0, 1));
        wd = $urandom;
        model(w, sz, sx, a, wd, e, d);
        if (w) stores++;
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        vectors++;
        if (resp_valid !== 1'b1 || resp_err !== e || resp_data !== d || ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_%0d: valid=%b err=%b data=%h ready=%b want 1/%b/%h/1", i, resp_valid, resp_err, resp_data, ready, e, d);
        end
      end else begin
        req = 1'b0;
        @(posedge clk); #1;
      end
    end
    vectors++;
    if (wr_cnt - w0 != stores || mem_diffs() != 0) begin
      miscompares++;
      $display("FAIL b2b_memory: writes=%0d diffs=%0d want %0d/0", wr_cnt - w0, mem_diffs(), stores);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_merge_hold();
    test_reset_in_merge();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
